// File: rtl/instr_encoder.sv
// Instruction encoder/loader: packs class+operand requests into MIPS words and writes them to imem.
// Optional NOP padding up to DEPTH on finish_i is enabled by defining INSTR_ENCODER_NOP_PAD_EN.
module instr_encoder #(
    parameter int unsigned DEPTH      = 64,
    parameter logic [31:0] START_ADDR = 32'h0040_0000,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [3:0]                    class_i,
    input  logic [4:0]                    rs_i,
    input  logic [4:0]                    rt_i,
    input  logic [4:0]                    rd_i,
    input  logic [4:0]                    shamt_i,
    input  logic [5:0]                    funct_i,
    input  logic [15:0]                   imm_i,
    input  logic [25:0]                   target_i,
    input  logic                          finish_i,
    output logic                          imem_we_o,
    output logic [ADDR_WIDTH-1:0]         imem_addr_o,
    output logic [31:0]                   imem_wdata_o,
    output logic [$clog2(DEPTH+1)-1:0]    word_count_o,
    output logic                          full_o,
    output logic                          err_o,
    output logic                          done_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef INSTR_ENCODER_NOP_PAD_EN
    typedef enum logic [1:0] {LOAD, FULL, DONE, PAD} state_t;
`else
    typedef enum logic [1:0] {LOAD, FULL, DONE} state_t;
`endif

    state_t         state;
    logic [31:0]    enc_word;
    logic           enc_valid;
    logic           accept;
    logic           do_write;
    logic [CW-1:0]  cnt_inc;
    logic [CW-1:0]  cnt_plus1;

    // Class-to-word encoding; classes 10..14 are flagged invalid
    always_comb begin
        enc_word  = 32'h0;
        enc_valid = 1'b1;
        case (class_i)
            4'd0:    enc_word = {6'h08, rs_i, rt_i, imm_i};
            4'd1:    enc_word = {6'h0D, rs_i, rt_i, imm_i};
            4'd2:    enc_word = {6'h0F, 5'd0, rt_i, imm_i};
            4'd3:    enc_word = {6'h0C, rs_i, rt_i, imm_i};
            4'd4:    enc_word = {6'h23, rs_i, rt_i, imm_i};
            4'd5:    enc_word = {6'h2B, rs_i, rt_i, imm_i};
            4'd6:    enc_word = {6'h04, rs_i, rt_i, imm_i};
            4'd7:    enc_word = {6'h05, rs_i, rt_i, imm_i};
            4'd8:    enc_word = {6'h02, target_i};
            4'd9:    enc_word = {6'h03, target_i};
            4'd15:   enc_word = {6'h00, rs_i, rt_i, rd_i, shamt_i, funct_i};
            default: enc_valid = 1'b0;
        endcase
    end

    assign accept    = req_valid_i && req_ready_o;
    assign do_write  = accept && enc_valid;
    assign cnt_plus1 = word_count_o + CW'(1);
    assign cnt_inc   = do_write ? cnt_plus1 : word_count_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            req_ready_o  <= 1'b1;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= ADDR_WIDTH'(START_ADDR);
            imem_wdata_o <= 32'h0;
            word_count_o <= '0;
            full_o       <= 1'b0;
            err_o        <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            imem_we_o <= 1'b0;
            // The address advances once the word written last cycle has been presented
            if (imem_we_o) begin
                imem_addr_o <= imem_addr_o + ADDR_WIDTH'(4);
            end
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (enc_valid) begin
                            imem_we_o    <= 1'b1;
                            imem_wdata_o <= enc_word;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    word_count_o <= cnt_inc;
                    full_o       <= (cnt_inc == CW'(DEPTH));
                    if (finish_i) begin
                        req_ready_o <= 1'b0;
`ifdef INSTR_ENCODER_NOP_PAD_EN
                        if (cnt_inc != CW'(DEPTH)) begin
                            state <= PAD;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
`else
                        state  <= DONE;
                        done_o <= 1'b1;
`endif
                    end else if (cnt_inc == CW'(DEPTH)) begin
                        state       <= FULL;
                        req_ready_o <= 1'b0;
                    end
                end
                FULL: begin
                    if (finish_i) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
`ifdef INSTR_ENCODER_NOP_PAD_EN
                PAD: begin
                    imem_we_o    <= 1'b1;
                    imem_wdata_o <= 32'h0;
                    word_count_o <= cnt_plus1;
                    full_o       <= (cnt_plus1 == CW'(DEPTH));
                    if (cnt_plus1 == CW'(DEPTH)) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, full/err/finish/reset corners, optional NOP padding.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  cls;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        finish;

    logic        rdy0, we0, full0, err0, done0;
    logic [31:0] addr0, wd0;
    logic [6:0]  cnt0;
    logic        rdy1, we1, full1, err1, done1;
    logic [31:0] addr1, wd1;
    logic [2:0]  cnt1;
    logic        rdy2, we2, full2, err2, done2;
    logic [31:0] addr2, wd2;
    logic [3:0]  cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(64)) u0 (
        .clk(clk), .reset(reset), .req_valid_i(valid), .req_ready_o(rdy0), .class_i(cls),
        .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct), .imm_i(imm),
        .target_i(target), .finish_i(finish), .imem_we_o(we0), .imem_addr_o(addr0),
        .imem_wdata_o(wd0), .word_count_o(cnt0), .full_o(full0), .err_o(err0), .done_o(done0));

    instr_encoder #(.DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .req_valid_i(valid), .req_ready_o(rdy1), .class_i(cls),
        .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct), .imm_i(imm),
        .target_i(target), .finish_i(finish), .imem_we_o(we1), .imem_addr_o(addr1),
        .imem_wdata_o(wd1), .word_count_o(cnt1), .full_o(full1), .err_o(err1), .done_o(done1));

    instr_encoder #(.DEPTH(8)) u2 (
        .clk(clk), .reset(reset), .req_valid_i(valid), .req_ready_o(rdy2), .class_i(cls),
        .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct), .imm_i(imm),
        .target_i(target), .finish_i(finish), .imem_we_o(we2), .imem_addr_o(addr2),
        .imem_wdata_o(wd2), .word_count_o(cnt2), .full_o(full2), .err_o(err2), .done_o(done2));

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        wr;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [3:0] c, input logic [4:0] s, input logic [4:0] t,
                                input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f,
                                input logic [15:0] im, input logic [25:0] tg,
                                input logic w, input logic [31:0] word);
        vec_t v;
        v.cls = c; v.rs = s; v.rt = t; v.rd = d; v.shamt = sh; v.funct = f;
        v.imm = im; v.target = tg; v.wr = w; v.word = word;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        valid = 1'b1; cls = v.cls; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.shamt;
        funct = v.funct; imm = v.imm; target = v.target;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; valid = 1'b0; finish = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_addr;
        int          exp_cnt;
        logic        exp_err;
        int          nwr;
        int          waited;

        reset = 1'b1; valid = 1'b0; finish = 1'b0; cls = '0; rs = '0; rt = '0; rd = '0;
        shamt = '0; funct = '0; imm = '0; target = '0;

        // Encoding table; unused fields carry junk that must be ignored
        vecs[0]  = mk(4'd0,  5'd0,  5'd8,  5'd0,  5'd0, 6'h00, 16'h0005, 26'h0,       1'b1, 32'h20080005);
        vecs[1]  = mk(4'd15, 5'd8,  5'd9,  5'd10, 5'd0, 6'h20, 16'hBEEF, 26'h3ABCDEF, 1'b1, 32'h01095020);
        vecs[2]  = mk(4'd4,  5'd29, 5'd8,  5'd3,  5'd7, 6'h11, 16'h0004, 26'h0,       1'b1, 32'h8FA80004);
        vecs[3]  = mk(4'd8,  5'd5,  5'd6,  5'd7,  5'd1, 6'h3F, 16'h1234, 26'h0100008, 1'b1, 32'h08100008);
        vecs[4]  = mk(4'd2,  5'd5,  5'd1,  5'd0,  5'd0, 6'h00, 16'h1001, 26'h0,       1'b1, 32'h3C011001);
        vecs[5]  = mk(4'd12, 5'd1,  5'd2,  5'd3,  5'd4, 6'h05, 16'h7777, 26'h1,       1'b0, 32'h0);
        vecs[6]  = mk(4'd1,  5'd1,  5'd2,  5'd0,  5'd0, 6'h00, 16'hFFFF, 26'h0,       1'b1, 32'h3422FFFF);
        vecs[7]  = mk(4'd3,  5'd3,  5'd4,  5'd0,  5'd0, 6'h00, 16'h00FF, 26'h0,       1'b1, 32'h306400FF);
        vecs[8]  = mk(4'd5,  5'd29, 5'd31, 5'd0,  5'd0, 6'h00, 16'hFFFC, 26'h0,       1'b1, 32'hAFBFFFFC);
        vecs[9]  = mk(4'd6,  5'd8,  5'd9,  5'd0,  5'd0, 6'h00, 16'hFFFE, 26'h0,       1'b1, 32'h1109FFFE);
        vecs[10] = mk(4'd7,  5'd8,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0003, 26'h0,       1'b1, 32'h15000003);
        vecs[11] = mk(4'd9,  5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 1'b1, 32'h0FFFFFFF);
        vecs[12] = mk(4'd10, 5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0000, 26'h0,       1'b0, 32'h0);

        do_reset();
        @(negedge clk);
        chk("rst_ready", 32'(rdy0), 32'd1);
        chk("rst_addr", addr0, 32'h0040_0000);
        chk("rst_we", 32'(we0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_wdata", wd0, 32'h0);

        // Back-to-back table: result of vector i is sampled while vector i+1 is driven
        exp_addr = 32'h0040_0000; exp_cnt = 0; exp_err = 1'b0;
        for (int i = 0; i <= 13; i++) begin
            if (i > 0) begin
                if (vecs[i-1].wr) begin
                    exp_cnt++;
                    chk($sformatf("v%0d_we", i-1), 32'(we0), 32'd1);
                    chk($sformatf("v%0d_word", i-1), wd0, vecs[i-1].word);
                    chk($sformatf("v%0d_addr", i-1), addr0, exp_addr);
                    exp_addr += 32'd4;
                end else begin
                    exp_err = 1'b1;
                    chk($sformatf("v%0d_we", i-1), 32'(we0), 32'd0);
                end
                chk($sformatf("v%0d_cnt", i-1), 32'(cnt0), 32'(exp_cnt));
                chk($sformatf("v%0d_err", i-1), 32'(err0), 32'(exp_err));
                chk($sformatf("v%0d_ready", i-1), 32'(rdy0), 32'd1);
            end
            if (i < 13) drive(vecs[i]);
            else valid = 1'b0;
            @(negedge clk);
        end
        chk("idle_we", 32'(we0), 32'd0);
        chk("idle_addr", addr0, exp_addr);

        // DEPTH=4 instance: five requests offered, only four accepted
        do_reset();
        drive(vecs[0]);
        nwr = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (we1) nwr++;
            if (c == 3) begin
                chk("full_ready_after4", 32'(rdy1), 32'd0);
                chk("full_flag_after4", 32'(full1), 32'd1);
            end
            if (c == 5) valid = 1'b0;
        end
        chk("full_writes", 32'(nwr), 32'd4);
        chk("full_cnt", 32'(cnt1), 32'd4);
        chk("full_flag", 32'(full1), 32'd1);
        chk("full_ready", 32'(rdy1), 32'd0);
        chk("full_addr", addr1, 32'h0040_0010);

        // finish_i together with an accepted request: word lands, then DONE
        do_reset();
        drive(vecs[0]);
        @(negedge clk);
        drive(vecs[2]);
        finish = 1'b1;
        @(negedge clk);
        valid = 1'b0; finish = 1'b0;
        chk("fin_we", 32'(we0), 32'd1);
        chk("fin_word", wd0, 32'h8FA80004);
        chk("fin_addr", addr0, 32'h0040_0004);
        chk("fin_ready", 32'(rdy0), 32'd0);
        waited = 0;
        while (!done0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("fin_done", 32'(done0), 32'd1);
        chk("fin_done_ready", 32'(rdy0), 32'd0);
`ifdef INSTR_ENCODER_NOP_PAD_EN
        chk("fin_cnt", 32'(cnt0), 32'd64);
`else
        chk("fin_cnt", 32'(cnt0), 32'd2);
`endif
        // finish_i and requests in DONE are ignored
        @(negedge clk);
        drive(vecs[0]);
        finish = 1'b1;
        @(negedge clk);
        valid = 1'b0; finish = 1'b0;
        @(negedge clk);
        chk("done_hold_we", 32'(we0), 32'd0);
        chk("done_hold", 32'(done0), 32'd1);
`ifdef INSTR_ENCODER_NOP_PAD_EN
        chk("done_hold_cnt", 32'(cnt0), 32'd64);
`else
        chk("done_hold_cnt", 32'(cnt0), 32'd2);
`endif

        // Reset with a write pending aborts it and restarts the address
        do_reset();
        drive(vecs[0]);
        @(negedge clk);
        drive(vecs[1]);
        @(negedge clk);
        chk("pre_rst_cnt", 32'(cnt0), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
        chk("mid_rst_we", 32'(we0), 32'd0);
        chk("mid_rst_cnt", 32'(cnt0), 32'd0);
        chk("mid_rst_addr", addr0, 32'h0040_0000);
        drive(vecs[4]);
        @(negedge clk);
        valid = 1'b0;
        chk("post_rst_word", wd0, 32'h3C011001);
        chk("post_rst_addr", addr0, 32'h0040_0000);
        chk("post_rst_cnt", 32'(cnt0), 32'd1);

        // DEPTH=8 instance: three words then finish_i
        do_reset();
        drive(vecs[0]);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        valid = 1'b0; finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        exp_addr = 32'h0040_000C;
        nwr = 0;
        for (int c = 0; c < 10; c++) begin
            if (we2) begin
                chk($sformatf("pad%0d_word", nwr), wd2, 32'h0);
                chk($sformatf("pad%0d_addr", nwr), addr2, exp_addr);
                exp_addr += 32'd4;
                nwr++;
            end
            @(negedge clk);
        end
        chk("pad_done", 32'(done2), 32'd1);
        chk("pad_ready", 32'(rdy2), 32'd0);
`ifdef INSTR_ENCODER_NOP_PAD_EN
        chk("pad_writes", 32'(nwr), 32'd5);
        chk("pad_cnt", 32'(cnt2), 32'd8);
        chk("pad_full", 32'(full2), 32'd1);
`else
        chk("pad_writes", 32'(nwr), 32'd0);
        chk("pad_cnt", 32'(cnt2), 32'd3);
        chk("pad_full", 32'(full2), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Instruction encoder and loader: the encoder counterpart of the control decoder. It accepts instruction requests over a valid/ready handshake, each giving an instruction class plus operand fields. It packs each request into a 32-bit MIPS word and writes it sequentially into instruction memory starting at START_ADDR. It is used to preload programs for simulation and bring-up.

Parameters:
DEPTH, 64, instruction-memory capacity in words; the loader never writes more than DEPTH words.
START_ADDR, 32'h0040_0000, byte address of the first word written.
ADDR_WIDTH, 32, width of imem_addr_o.

Ports:
clk  input  1  system clock
reset  input  1  one clock; reset is synchronous and active-high
req_valid_i  input  1  request present
req_ready_o  output  1  encoder can accept a request this cycle
class_i  input  4  instruction class: 0 ADDI, 1 ORI, 2 LUI, 3 ANDI, 4 LW, 5 SW, 6 BEQ, 7 BNE, 8 J, 9 JAL, 15 R-type
rs_i  input  5  rs field
rt_i  input  5  rt field
rd_i  input  5  rd field (R-type only)
shamt_i  input  5  shamt field (R-type only)
funct_i  input  6  funct field (R-type only)
imm_i  input  16  immediate / offset (I-type)
target_i  input  26  jump target (J-type)
finish_i  input  1  end-of-program pulse
imem_we_o  output  1  instruction-memory write enable
imem_addr_o  output  ADDR_WIDTH  byte write address
imem_wdata_o  output  32  encoded word
word_count_o  output  clog2(DEPTH+1)  number of words written
full_o  output  1  word_count_o == DEPTH
err_o  output  1  sticky: an invalid class was received
done_o  output  1  loading complete

Behaviour:
- Reset values: all outputs 0 except req_ready_o=1 and imem_addr_o=START_ADDR. State goes to LOAD.
- Reset mid-operation aborts any pending write and restarts at START_ADDR with count 0.
- States: LOAD, FULL, DONE (plus PAD when the optional feature is enabled).
- Handshake: a transfer occurs when req_valid_i && req_ready_o. req_ready_o = (state==LOAD) && !full_o. Throughput is one request per cycle.
- Latency: the cycle after an accepted valid request, imem_we_o=1 for exactly one cycle, with imem_wdata_o holding the encoded word and imem_addr_o the current address.
- After each write: address += 4 and word_count_o += 1. The address wraps modulo 2^ADDR_WIDTH.
- Encoding:
  - R-type: {6'h00, rs, rt, rd, shamt, funct}.
  - I-type: {op, rs, rt, imm}. Opcodes: ADDI 0x08, ORI 0x0D, LUI 0x0F, ANDI 0x0C, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05. For LUI the rs field is forced to 0.
  - J-type: {op, target}. Opcodes: J 0x02, JAL 0x03.
  - Unused input fields are ignored.
- Invalid class (10..14): the request is consumed, nothing is written, the count is unchanged, and err_o is set. err_o clears only on reset.
- When word_count_o reaches DEPTH: go to FULL and drop req_ready_o. full_o stays 1.
- finish_i in LOAD or FULL: go to DONE, set done_o=1 and req_ready_o=0. DONE is held until reset.
- finish_i in the same cycle as an accepted request: the request is written first, then the state goes to DONE.
- finish_i in DONE is ignored.

Optional Feature:
Macro INSTR_ENCODER_NOP_PAD_EN.
- Defined: finish_i with count < DEPTH enters PAD. PAD writes 32'h0000_0000 (NOP) on consecutive cycles, with imem_we_o=1 every cycle, until count == DEPTH. It then enters DONE. full_o is 1 at the end of padding.
- Not defined: finish_i goes directly to DONE and memory above the last word is untouched.

Test Plan:
- After reset, ADDI class 0, rs=0, rt=8, imm=5 -> next cycle imem_we_o=1, addr 0x00400000, wdata 0x20080005, count 1.
- Back-to-back requests:
  - R-type class 15, rs=8, rt=9, rd=10, shamt=0, funct=0x20 -> 0x01095020 @0x00400004.
  - LW class 4, rs=29, rt=8, imm=4 -> 0x8FA80004 @0x00400008.
  - J class 8, target=0x0100008 -> 0x08100008 @0x0040000C.
  - One write per cycle.
- LUI class 2, rs_i=5, rt=1, imm=0x1001 -> 0x3C011001 (rs forced 0). Then class 12 -> no write, err_o=1, count unchanged.
- DEPTH=4: send 5 requests -> 4 writes, full_o=1, req_ready_o=0 after the 4th, and the 5th is not accepted.
- finish_i with an accepted request in the same cycle -> that word is written, then done_o=1 and req_ready_o=0. Reset mid-load -> count 0 and address 0x00400000.
- With INSTR_ENCODER_NOP_PAD_EN, DEPTH=8: 3 words then finish_i -> 5 consecutive zero writes @0x0040000C..0x0040001C, then done_o=1.
